// File: rtl/adder_pkg.sv
// Shared types and default geometry for the pipelined adder.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide ripple slice of the pipelined adder.
// The full-width operand/result vectors travel with the operation, so upper
// operand chunks are naturally skew-delayed and lower result chunks deskewed.
module adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int IDX   = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    input  logic             in_ovf,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic             carry_into_msb;
    logic             ovf_next;
    logic [WIDTH-1:0] sum_next;

    // Ripple-add this stage's chunk and splice it into the travelling result.
    always_comb begin
        a_chunk        = in_a[IDX*CHUNK +: CHUNK];
        b_chunk        = in_b[IDX*CHUNK +: CHUNK];
        chunk_res      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, in_carry};
        // Carry into the top bit of the chunk, recovered from the sum bit.
        carry_into_msb = chunk_res[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
        ovf_next       = LAST ? (carry_into_msb ^ chunk_res[CHUNK]) : in_ovf;
        sum_next       = in_sum;
        sum_next[IDX*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    end

    // Stage register: holds under stall, data only loads for real operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (!hold) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_a     <= in_a;
                out_b     <= in_b;
                out_sum   <= sum_next;
                out_carry <= chunk_res[CHUNK];
                out_ovf   <= ovf_next;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH/CHUNK ripple slices, one per stage,
// with a valid/ready handshake and a whole-pipe stall.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NST = WIDTH / CHUNK;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_geometry
            $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    op_e              op;
    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             carry_eff;

    logic [NST:0]     v_p;
    logic [WIDTH-1:0] a_p [NST+1];
    logic [WIDTH-1:0] b_p [NST+1];
    logic [WIDTH-1:0] s_p [NST+1];
    logic [NST:0]     c_p;
    logic [NST:0]     o_p;

    // Subtract is a + ~b + ~c_in; the inversion happens once at the entry.
    always_comb begin
        op        = sub ? OP_SUB : OP_ADD;
        b_eff     = (op == OP_SUB) ? ~b : b;
        carry_eff = (op == OP_SUB) ? ~c_in : c_in;
    end

    assign stall    = v_p[NST] && !out_ready;
    assign in_ready = !stall;

    assign v_p[0] = in_valid && in_ready;
    assign a_p[0] = a;
    assign b_p[0] = b_eff;
    assign s_p[0] = '0;
    assign c_p[0] = carry_eff;
    assign o_p[0] = 1'b0;

    generate
        for (genvar k = 0; k < NST; k++) begin : g_stage
            adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (k),
                .LAST  (k == NST - 1)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .hold      (stall),
                .in_valid  (v_p[k]),
                .in_a      (a_p[k]),
                .in_b      (b_p[k]),
                .in_sum    (s_p[k]),
                .in_carry  (c_p[k]),
                .in_ovf    (o_p[k]),
                .out_valid (v_p[k+1]),
                .out_a     (a_p[k+1]),
                .out_b     (b_p[k+1]),
                .out_sum   (s_p[k+1]),
                .out_carry (c_p[k+1]),
                .out_ovf   (o_p[k+1])
            );
        end
    endgenerate

    assign out_valid = v_p[NST];
    assign sum       = s_p[NST];
    assign c_out     = c_p[NST];
    assign ovf       = o_p[NST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: a 16/4 instance and a 3/1 instance.
module tb_pipelined_adder;

    localparam int W16 = 16;
    localparam int N16 = 4;
    localparam int W3  = 3;
    localparam int N3  = 3;

    typedef struct {
        logic [15:0] sum;
        logic        c_out;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;

    logic        t_in_valid, t_in_ready, t_c_in, t_sub, t_out_valid, t_out_ready, t_c_out, t_ovf;
    logic [2:0]  t_a, t_b, t_sum;

    pipelined_adder #(.WIDTH(W16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(W3), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .a(t_a), .b(t_b), .c_in(t_c_in), .sub(t_sub), .out_valid(t_out_valid),
        .out_ready(t_out_ready), .sum(t_sum), .c_out(t_c_out), .ovf(t_ovf)
    );

    exp_t q16[$];
    exp_t q3[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   stall_cycles = 0;
    bit   was_stall = 0;
    logic [15:0] held_sum;
    logic        held_c, held_o;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input longint av, input longint bv,
                                   input bit ci, input bit sb);
        exp_t e;
        longint m, half, full, sa, sbs, sr;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (av >= half) ? av - m : av;
        sbs  = (bv >= half) ? bv - m : bv;
        if (sb) begin
            full    = av - bv - longint'(ci);
            sr      = sa - sbs - longint'(ci);
            e.c_out = (full >= 0);
        end else begin
            full    = av + bv + longint'(ci);
            sr      = sa + sbs + longint'(ci);
            e.c_out = (full >= m);
        end
        e.sum = 16'(full & (m - 1));
        e.ovf = (sr >= half) || (sr < -half);
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.c_out = c; e.ovf = o; e.acc = 0; e.lat = 0;
        return e;
    endfunction

    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic sb, input bit lat, input bit directed, input exp_t ex);
        exp_t e;
        int n = 0;
        a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            total++;
            $display("FAIL accept16: in_ready stuck at 0 for %0d cycles", n);
        end else begin
            e     = directed ? ex : model(W16, longint'(av), longint'(bv), ci, sb);
            e.acc = cyc;
            e.lat = lat;
            q16.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [2:0] av, input logic [2:0] bv, input logic ci,
                         input logic sb, input bit directed, input exp_t ex);
        exp_t e;
        int n = 0;
        t_a = av; t_b = bv; t_c_in = ci; t_sub = sb; t_in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!t_in_ready && n < 50);
        if (!t_in_ready) begin
            total++;
            $display("FAIL accept3: in_ready stuck at 0 for %0d cycles", n);
        end else begin
            e     = directed ? ex : model(W3, longint'(av), longint'(bv), ci, sb);
            e.acc = cyc;
            e.lat = 1;
            q3.push_back(e);
        end
        @(posedge clk); #1;
        t_in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((q16.size() != 0 || q3.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (q16.size() != 0 || q3.size() != 0) begin
            total++;
            $display("FAIL drain: %0d/%0d results never arrived", q16.size(), q3.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor for the 16-bit instance: pops on each output transfer, checks stall freeze.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && was_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_sum_held", sum, held_sum);
            check("stall_cout_held", c_out, held_c);
            check("stall_ovf_held", ovf, held_o);
        end
        was_stall = rst_n && out_valid && !out_ready;
        held_sum  = sum;
        held_c    = c_out;
        held_o    = ovf;
        if (was_stall) begin
            stall_cycles++;
            check("in_ready_stall", in_ready, 0);
        end
        if (rst_n && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                total++;
                $display("FAIL unexpected16: sum=0x%0h with no operation outstanding", sum);
            end else begin
                e = q16.pop_front();
                check("sum16", sum, e.sum);
                check("cout16", c_out, e.c_out);
                check("ovf16", ovf, e.ovf);
                if (e.lat) check("latency16", cyc - e.acc, N16);
            end
        end
    end

    // Monitor for the 3-bit instance.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] es;
        if (rst_n && t_out_valid && t_out_ready) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL unexpected3: sum=0x%0h with no operation outstanding", t_sum);
            end else begin
                e  = q3.pop_front();
                es = e.sum;
                check("sum3", t_sum, es[2:0]);
                check("cout3", t_c_out, e.c_out);
                check("ovf3", t_ovf, e.ovf);
                if (e.lat) check("latency3", cyc - e.acc, N3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    bit rand_done;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; c_in = 0; sub = 0; out_ready = 1;
        t_in_valid = 0; t_a = 0; t_b = 0; t_c_in = 0; t_sub = 0; t_out_ready = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid3", t_out_valid, 0);
        #20;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_sum", sum, 0);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed add / subtract vectors, one at a time with latency checks.
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1, mk(16'h0000, 1, 0)); drain();
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, 1, mk(16'h8000, 0, 1)); drain();
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, 1, 1, mk(16'hFFFE, 0, 0)); drain();
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, 1, 1, mk(16'h7FFF, 1, 1)); drain();

        // Six back-to-back ops, mixed modes, out_ready held high.
        for (int i = 0; i < 6; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2), 1, 0, mk(0, 0, 0));
        drain();

        // Stream with a three-cycle downstream stall in the middle.
        stall_cycles = 0;
        fork
            for (int i = 0; i < 10; i++)
                send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 0, mk(0, 0, 0));
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_seen", stall_cycles, 3);

        // Randomized traffic with random backpressure and input gaps.
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 0, mk(0, 0, 0));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++)
            send16(16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 0, mk(0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", c_out, 0);
        check("midrst_in_ready", in_ready, 1);
        q16.delete();
        q3.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk); #1;

        // Narrow instance: lab vectors, then a few random add/sub ops.
        send3(3'b111, 3'b111, 1'b1, 1'b0, 1, mk(16'h0007, 1, 0)); drain();
        send3(3'b011, 3'b001, 1'b1, 1'b0, 1, mk(16'h0005, 0, 1)); drain();
        send3(3'b101, 3'b010, 1'b0, 1'b0, 1, mk(16'h0007, 0, 0)); drain();
        for (int i = 0; i < 12; i++)
            send3(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 0, mk(0, 0, 0));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
